// File: rtl/vx_vgpr_mport_file.sv
// Banked multi-port vector register file, round-robin bank arbitration.
// Optional same-cycle write-to-read bypass: define VX_VGPR_BYPASS_EN.
module vx_vgpr_mport_file #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int DATAW     = 128,
  parameter int DEPTH     = 256,
  parameter int TAG_W     = 4,
  parameter int PERF_W    = 32,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int BYTES    = DATAW / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        req_valid_i,
  input  logic [NUM_REQS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQS*TAG_W-1:0]  req_tag_i,
  output logic [NUM_REQS-1:0]        req_ready_o,
  output logic [NUM_REQS-1:0]        rsp_valid_o,
  output logic [NUM_REQS*DATAW-1:0]  rsp_data_o,
  output logic [NUM_REQS*TAG_W-1:0]  rsp_tag_o,
  input  logic [NUM_REQS-1:0]        rsp_ready_i,
  input  logic                       wr_valid_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [BYTES-1:0]           wr_byteen_i,
  input  logic [DATAW-1:0]           wr_data_i,
  output logic [PERF_W-1:0]          perf_collisions_o
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W = (ADDR_W > BANK_BITS) ? ADDR_W - BANK_BITS : 1;
  localparam int ROWS = DEPTH / NUM_BANKS;
  localparam int REQ_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [DATAW-1:0] mem_q [NUM_BANKS][ROWS];

  logic [NUM_REQS-1:0]                rsp_valid_q;
  logic [NUM_REQS-1:0][DATAW-1:0]     rsp_data_q;
  logic [NUM_REQS-1:0][TAG_W-1:0]     rsp_tag_q;
  logic [NUM_BANKS-1:0][REQ_W-1:0]    ptr_q, ptr_d;
  logic [PERF_W-1:0]                  perf_q, perf_d;

  logic [NUM_REQS-1:0]            elig, gnt;
  logic [BANK_W-1:0]              rbank [NUM_REQS];
  logic [ROW_W-1:0]               rrow  [NUM_REQS];
  logic [NUM_REQS-1:0][DATAW-1:0] rdata;
  logic [BANK_W-1:0]              wbank;
  logic [ROW_W-1:0]               wrow;

  always_comb begin
    wbank = BANK_W'(wr_addr_i & ADDR_W'(NUM_BANKS - 1));
    wrow  = ROW_W'(wr_addr_i >> BANK_BITS);
    for (int i = 0; i < NUM_REQS; i++) begin
      rbank[i] = BANK_W'(req_addr_i[i*ADDR_W +: ADDR_W]
                 & ADDR_W'(NUM_BANKS - 1));
      rrow[i]  = ROW_W'(req_addr_i[i*ADDR_W +: ADDR_W] >> BANK_BITS);
      rdata[i] = mem_q[rbank[i]][rrow[i]];
`ifdef VX_VGPR_BYPASS_EN
      if (wr_valid_i && req_addr_i[i*ADDR_W +: ADDR_W] == wr_addr_i) begin
        for (int j = 0; j < BYTES; j++)
          if (wr_byteen_i[j]) rdata[i][j*8 +: 8] = wr_data_i[j*8 +: 8];
      end
`endif
    end
  end

  // A stalled slot frees up when its consumer drains it this same cycle.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    elig  = req_valid_i & (~rsp_valid_q | rsp_ready_i);
    gnt   = '0;
    ptr_d = ptr_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      found = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
        idx = (int'(ptr_q[b]) + k) % NUM_REQS;
        if (!found && elig[idx] && rbank[idx] == BANK_W'(b)) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d[b] = REQ_W'((idx + 1) % NUM_REQS);
        end
      end
    end
    if (reset) gnt = '0;
  end

  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NUM_REQS; i++)
      if (elig[i] && !gnt[i]) perf_d = perf_d + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_valid_i) begin
      for (int j = 0; j < BYTES; j++)
        if (wr_byteen_i[j])
          mem_q[wbank][wrow][j*8 +: 8] <= wr_data_i[j*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      ptr_q       <= '0;
      perf_q      <= '0;
    end else begin
      ptr_q  <= ptr_d;
      perf_q <= perf_d;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (gnt[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data_q[i]  <= rdata[i];
          rsp_tag_q[i]   <= req_tag_i[i*TAG_W +: TAG_W];
        end else if (rsp_ready_i[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready_o       = gnt;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_tag_o         = rsp_tag_q;
  assign perf_collisions_o = perf_q;

endmodule

// File: tb/tb_vx_vgpr_mport_file.sv
// Directed self-checking bench for vx_vgpr_mport_file.
// Define VX_VGPR_BYPASS_EN here too when building the bypass variant.
module tb_vx_vgpr_mport_file;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [31:0]  req_addr;
  logic [15:0]  req_tag;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [511:0] rsp_data;
  logic [15:0]  rsp_tag;
  logic [3:0]   rsp_ready;
  logic         wr_valid;
  logic [7:0]   wr_addr;
  logic [15:0]  wr_byteen;
  logic [127:0] wr_data;
  logic [31:0]  perf;

  int ncmp = 0;
  int nerr = 0;

  vx_vgpr_mport_file dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid_i       (req_valid),
    .req_addr_i        (req_addr),
    .req_tag_i         (req_tag),
    .req_ready_o       (req_ready),
    .rsp_valid_o       (rsp_valid),
    .rsp_data_o        (rsp_data),
    .rsp_tag_o         (rsp_tag),
    .rsp_ready_i       (rsp_ready),
    .wr_valid_i        (wr_valid),
    .wr_addr_i         (wr_addr),
    .wr_byteen_i       (wr_byteen),
    .wr_data_i         (wr_data),
    .perf_collisions_o (perf)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] val(input int a);
    logic [7:0] b;
    b = 8'(a) ^ 8'h3C;
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int t);
    req_addr[i*8 +: 8] = 8'(a);
    req_tag[i*4 +: 4]  = 4'(t);
  endtask

  task automatic wr(input int a, input logic [127:0] d,
                    input logic [15:0] be);
    wr_valid  = 1'b1;
    wr_addr   = 8'(a);
    wr_data   = d;
    wr_byteen = be;
    @(negedge clk);
    wr_valid  = 1'b0;
  endtask

  initial begin
    logic [127:0] merged;
    logic [127:0] exp5;
    int bank1 [4];
    bank1  = '{1, 5, 9, 13};
    merged = {{12{8'h11}}, {4{8'hFF}}};
    reset = 1'b1;
    req_valid = 4'hF;
    req_addr = '0;
    req_tag = '0;
    rsp_ready = 4'hF;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_byteen = '0;
    wr_data = '0;
    for (int i = 0; i < 4; i++) set_req(i, i, i);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 128'(req_ready), 128'h0);
    chk("rst_valid", 128'(rsp_valid), 128'h0);
    chk("rst_perf", 128'(perf), 128'h0);
    chk("rst_data0", rsp_data[127:0], 128'h0);
    chk("rst_tag", 128'(rsp_tag), 128'h0);
    reset = 1'b0;
    req_valid = 4'h0;

    for (int a = 0; a < 4; a++) wr(a, val(a), 16'hFFFF);
    wr(5, val(5), 16'hFFFF);
    wr(9, val(9), 16'hFFFF);
    wr(13, val(13), 16'hFFFF);
    wr(7, {16{8'h11}}, 16'hFFFF);

    // all four requesters fight for bank 1
    for (int i = 0; i < 4; i++) set_req(i, bank1[i], i);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 128'(req_ready), 128'(4'b1 << (k % 4)));
      @(negedge clk);
      chk("rr_valid", 128'(rsp_valid), 128'(4'b1 << (k % 4)));
      chk("rr_data", rsp_data[(k%4)*128 +: 128], val(bank1[k % 4]));
      chk("rr_tag", 128'(rsp_tag[(k%4)*4 +: 4]), 128'(k % 4));
      chk("rr_perf", 128'(perf), 128'(3 * (k + 1)));
    end
    req_valid = 4'h0;
    @(negedge clk);

    // distinct banks: all granted at once
    for (int i = 0; i < 4; i++) set_req(i, i, 4 + i);
    req_valid = 4'hF;
    #1;
    chk("par_ready", 128'(req_ready), 128'hF);
    @(negedge clk);
    req_valid = 4'h0;
    chk("par_valid", 128'(rsp_valid), 128'hF);
    for (int i = 0; i < 4; i++) begin
      chk("par_data", rsp_data[i*128 +: 128], val(i));
      chk("par_tag", 128'(rsp_tag[i*4 +: 4]), 128'(4 + i));
    end
    chk("par_perf", 128'(perf), 128'd15);
    @(negedge clk);

    // write then read two cycles later
    wr(5, {16{8'hA5}}, 16'hFFFF);
    @(negedge clk);
    set_req(0, 5, 9);
    req_valid = 4'b0001;
    #1;
    chk("wr_rd_ready", 128'(req_ready), 128'h1);
    @(negedge clk);
    req_valid = 4'h0;
    chk("wr_rd_valid", 128'(rsp_valid), 128'h1);
    chk("wr_rd_data", rsp_data[127:0], {16{8'hA5}});
    chk("wr_rd_tag", 128'(rsp_tag[3:0]), 128'd9);
    @(negedge clk);

    // requester 2 stalls its consumer
    rsp_ready = 4'b1011;
    set_req(2, 2, 5);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("stl_valid", 128'(rsp_valid), 128'h4);
    chk("stl_data", rsp_data[256 +: 128], val(2));
    set_req(2, 0, 6);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stl_ready", 128'(req_ready), 128'h0);
      @(negedge clk);
      chk("stl_hold_d", rsp_data[256 +: 128], val(2));
      chk("stl_hold_t", 128'(rsp_tag[8 +: 4]), 128'd5);
      chk("stl_hold_v", 128'(rsp_valid), 128'h4);
    end
    rsp_ready = 4'hF;
    #1;
    chk("stl_rel_ready", 128'(req_ready), 128'h4);
    @(negedge clk);
    req_valid = 4'h0;
    chk("stl_new_data", rsp_data[256 +: 128], val(0));
    chk("stl_new_tag", 128'(rsp_tag[8 +: 4]), 128'd6);
    chk("stl_perf", 128'(perf), 128'd15);
    @(negedge clk);

    // same-cycle partial write and read of addr 7
    wr_valid = 1'b1;
    wr_addr = 8'd7;
    wr_data = {16{8'hFF}};
    wr_byteen = 16'h000F;
    set_req(1, 7, 2);
    req_valid = 4'b0010;
    @(negedge clk);
    wr_valid = 1'b0;
    req_valid = 4'h0;
`ifdef VX_VGPR_BYPASS_EN
    exp5 = merged;
`else
    exp5 = {16{8'h11}};
`endif
    chk("byp_data", rsp_data[128 +: 128], exp5);
    chk("byp_tag", 128'(rsp_tag[4 +: 4]), 128'd2);
    wr(7, 128'h0, 16'h0000);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'h0;
    chk("merge_data", rsp_data[128 +: 128], merged);
    @(negedge clk);

    // reset with four responses pending
    rsp_ready = 4'h0;
    for (int i = 0; i < 4; i++) set_req(i, i, i);
    req_valid = 4'hF;
    @(negedge clk);
    chk("pend_valid", 128'(rsp_valid), 128'hF);
    chk("pend_perf", 128'(perf), 128'd15);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 128'(req_ready), 128'h0);
    @(negedge clk);
    chk("mid_rst_valid", 128'(rsp_valid), 128'h0);
    chk("mid_rst_perf", 128'(perf), 128'h0);
    chk("mid_rst_data", rsp_data[384 +: 128], 128'h0);
    reset = 1'b0;
    rsp_ready = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, bank1[i], i);
    #1;
    chk("rr_restart0", 128'(req_ready), 128'h1);
    @(negedge clk);
    chk("rr_restart_perf", 128'(perf), 128'd3);
    #1;
    chk("rr_restart1", 128'(req_ready), 128'h2);
    req_valid = 4'h0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
